ederah_nfa_slot_ctrl: RTL and testbench
=======================================

// Module: ederah_nfa_slot_ctrl
// PURPOSE
//  Kernel-level run controller between the host AXI4-Stream pipes and the ederah engine core.
//  Caches the hashes of up to G_NFA_SLOTS resident NFAs and decides per run: reload (NFA then query
//  stream) or query-only, and which core slot is targeted. Gates input valid outside a run and
//  generates ap_idle/ap_done/ap_ready. Completion requires both input tlast and result tlast.
// PARAMETERS
//  G_NFA_SLOTS     4   resident NFA slots in core, >=1; slot index width SW = max(1,$clog2(G_NFA_SLOTS))
//  G_HASH_WIDTH    32  width of nfa_hash_i
//  G_CNT_WIDTH     32  width of beat counters
// PORTS
//  clk_i           in   1             single clock (data clock domain)
//  rst_i           in   1             synchronous reset, active high
//  ap_start_i      in   1             SDx start, level; rising edge starts a run
//  ap_idle_o       out  1             high while state==IDLE
//  ap_done_o       out  1             one-cycle pulse at run completion
//  ap_ready_o      out  1             equals ap_done_o
//  nfa_hash_i      in   G_HASH_WIDTH  NFA identity, sampled on the start edge
//  flush_i         in   1             invalidate all slots (honoured only in IDLE)
//  in_valid_i      in   1             host input tvalid
//  in_last_i       in   1             host input tlast
//  in_ready_i      in   1             core rd_ready (passes through to host tready outside this block)
//  core_valid_o    out  1             gated valid to core: in_valid_i & (state in READ_NFA/READ_QUERY)
//  core_stype_o    out  1             0 = NFA beat (READ_NFA), 1 = query beat (otherwise)
//  core_slot_o     out  SW            target slot for the current run
//  res_valid_i     in   1             result tvalid
//  res_ready_i     in   1             result tready
//  res_last_i      in   1             result tlast
//  hit_o           out  1             last lookup hit (held until next lookup)
//  nfa_beats_o     out  G_CNT_WIDTH   NFA beats accepted in current/last run
//  query_beats_o   out  G_CNT_WIDTH   query beats accepted in current/last run
// BEHAVIOUR
//  - Reset: state IDLE; all slot valid bits 0; victim ptr 0; ap_idle_o=1; ap_done_o=0; hit_o=0;
//    core_slot_o=0; counters 0; start-edge register 0. Reset mid-run aborts the run, no ap_done.
//  - Beat handshake: in_acc = in_valid_i & in_ready_i & core_valid_o; res_acc = res_valid_i&res_ready_i.
//  - States: IDLE -> LOOKUP -> {READ_NFA -> READ_QUERY | READ_QUERY} -> DRAIN -> DONE -> IDLE.
//  - IDLE: start edge (ap_start_i & ~ap_start_q) -> register hash, clear counters/flags -> LOOKUP.
//    flush_i in IDLE clears all valid bits; flush_i and start edge in same cycle: flush first, run misses.
//  - LOOKUP (exactly 1 cycle): compare hash to every valid slot. Hit -> core_slot_o=hit index
//    (lowest index if duplicates), hit_o=1, -> READ_QUERY. Miss -> core_slot_o=victim ptr, hit_o=0,
//    clear that slot's valid bit, -> READ_NFA. Hash value 0 is a legal identity.
//  - READ_NFA: count in_acc into nfa_beats_o; in_acc&in_last_i -> write hash to slot, set valid,
//    victim ptr = (ptr+1) mod G_NFA_SLOTS (wrap at G_NFA_SLOTS-1), -> READ_QUERY.
//  - READ_QUERY: count in_acc into query_beats_o; in_acc&in_last_i -> DRAIN.
//  - res_acc&res_last_i sets res_done flag in any non-IDLE state (result may finish before input).
//  - DRAIN: wait res_done (or res_acc&res_last_i this cycle) -> DONE.
//  - DONE: ap_done_o=ap_ready_o=1 for this cycle only -> IDLE. Start edges outside IDLE are ignored.
//  - core_valid_o=0 in IDLE/LOOKUP/DRAIN/DONE; host beats there stall (no acceptance counted).
//  - Counters saturate at all-ones; hold value after run for readout until next start edge.
//  - core_stype_o, core_slot_o, core_valid_o combinational from registered state (0-cycle path).
// TESTING
//  - Reset, start hash 0xA5A5_0001, 3 NFA + 2 query beats, 1 result last -> miss, slot 0, nfa=3,
//    query=2, one ap_done pulse, ap_idle back to 1.
//  - Repeat same hash -> hit_o=1, slot 0, READ_NFA skipped, stype=1 on every beat, nfa_beats=0.
//  - 5 distinct hashes with G_NFA_SLOTS=4 -> slots 0,1,2,3,0; 6th run with 1st hash misses (evicted).
//  - Result tlast accepted 4 cycles before input tlast -> ap_done exactly 2 cycles after input tlast
//    (DRAIN, DONE); never before.
//  - flush_i in IDLE then start with cached hash -> miss; start pulse during READ_QUERY -> ignored.
//  - rst_i asserted mid READ_NFA -> no ap_done, slot stays invalid, next run with same hash misses.

Source files
------------

// File: rtl/ederah_nfa_slot_ctrl.sv
// ederah_nfa_slot_ctrl: run controller that caches resident NFA hashes, picks reload vs query-only
// per run, steers host beats to a core slot and generates the ap_* handshake.
module ederah_nfa_slot_ctrl #(
    parameter int G_NFA_SLOTS  = 4,
    parameter int G_HASH_WIDTH = 32,
    parameter int G_CNT_WIDTH  = 32,
    localparam int SW = (G_NFA_SLOTS > 1) ? $clog2(G_NFA_SLOTS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ap_start_i,
    output logic                    ap_idle_o,
    output logic                    ap_done_o,
    output logic                    ap_ready_o,
    input  logic [G_HASH_WIDTH-1:0] nfa_hash_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    input  logic                    in_last_i,
    input  logic                    in_ready_i,
    output logic                    core_valid_o,
    output logic                    core_stype_o,
    output logic [SW-1:0]           core_slot_o,
    input  logic                    res_valid_i,
    input  logic                    res_ready_i,
    input  logic                    res_last_i,
    output logic                    hit_o,
    output logic [G_CNT_WIDTH-1:0]  nfa_beats_o,
    output logic [G_CNT_WIDTH-1:0]  query_beats_o
);
    typedef enum logic [2:0] {IDLE, LOOKUP, READ_NFA, READ_QUERY, DRAIN, DONE} state_t;
    state_t                  state_q, state_d;
    logic                    ap_start_q;
    logic [G_HASH_WIDTH-1:0] hash_q, hash_d;
    logic [G_HASH_WIDTH-1:0] tag_q [G_NFA_SLOTS];
    logic [G_HASH_WIDTH-1:0] tag_d [G_NFA_SLOTS];
    logic [G_NFA_SLOTS-1:0]  valid_q, valid_d;
    logic [SW-1:0]           victim_q, victim_d, slot_q, slot_d, hit_idx;
    logic                    hit_q, hit_d, res_done_q, res_done_d, hit_any;
    logic [G_CNT_WIDTH-1:0]  nfa_cnt_q, nfa_cnt_d, qry_cnt_q, qry_cnt_d;
    logic                    start_edge, in_acc, res_end;

    assign start_edge    = ap_start_i & ~ap_start_q;
    assign core_valid_o  = in_valid_i & (state_q == READ_NFA || state_q == READ_QUERY);
    assign core_stype_o  = state_q != READ_NFA;
    assign core_slot_o   = slot_q;
    assign in_acc        = in_valid_i & in_ready_i & core_valid_o;
    assign res_end       = res_valid_i & res_ready_i & res_last_i;
    assign ap_idle_o     = state_q == IDLE;
    assign ap_done_o     = state_q == DONE;
    assign ap_ready_o    = ap_done_o;
    assign hit_o         = hit_q;
    assign nfa_beats_o   = nfa_cnt_q;
    assign query_beats_o = qry_cnt_q;

    // Descending scan so the lowest matching index wins on duplicates.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = G_NFA_SLOTS - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == hash_q) begin
                hit_any = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hash_d     = hash_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        victim_d   = victim_q;
        slot_d     = slot_q;
        hit_d      = hit_q;
        res_done_d = res_done_q | (state_q != IDLE && res_end);
        nfa_cnt_d  = (state_q == READ_NFA && in_acc && ~&nfa_cnt_q) ? nfa_cnt_q + 1'b1 : nfa_cnt_q;
        qry_cnt_d  = (state_q == READ_QUERY && in_acc && ~&qry_cnt_q) ? qry_cnt_q + 1'b1 : qry_cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_i)
                    valid_d = '0;
                if (start_edge) begin
                    hash_d     = nfa_hash_i;
                    nfa_cnt_d  = '0;
                    qry_cnt_d  = '0;
                    res_done_d = 1'b0;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d   = hit_any;
                slot_d  = hit_any ? hit_idx : victim_q;
                state_d = hit_any ? READ_QUERY : READ_NFA;
                if (!hit_any)
                    valid_d[victim_q] = 1'b0;
            end
            READ_NFA: begin
                if (in_acc && in_last_i) begin
                    tag_d[slot_q]   = hash_q;
                    valid_d[slot_q] = 1'b1;
                    victim_d        = (victim_q == SW'(G_NFA_SLOTS - 1)) ? '0 : victim_q + 1'b1;
                    state_d         = READ_QUERY;
                end
            end
            READ_QUERY: state_d = (in_acc && in_last_i) ? DRAIN : READ_QUERY;
            DRAIN:      state_d = (res_done_q || res_end) ? DONE : DRAIN;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ap_start_q <= 1'b0;
            hash_q     <= '0;
            tag_q      <= '{default: '0};
            valid_q    <= '0;
            victim_q   <= '0;
            slot_q     <= '0;
            hit_q      <= 1'b0;
            res_done_q <= 1'b0;
            nfa_cnt_q  <= '0;
            qry_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ap_start_q <= ap_start_i;
            hash_q     <= hash_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            victim_q   <= victim_d;
            slot_q     <= slot_d;
            hit_q      <= hit_d;
            res_done_q <= res_done_d;
            nfa_cnt_q  <= nfa_cnt_d;
            qry_cnt_q  <= qry_cnt_d;
        end
    end
endmodule

// File: tb/tb_ederah_nfa_slot_ctrl.sv
// tb_ederah_nfa_slot_ctrl: random runs checked against a cache model of resident NFA slots.
module tb_ederah_nfa_slot_ctrl;
    localparam int N = 4;
    logic        clk = 0, rst = 1, ap_start = 0, flush = 0;
    logic        in_valid = 0, in_last = 0, in_ready = 0;
    logic        res_valid = 0, res_ready = 0, res_last = 0;
    logic [31:0] nfa_hash = '0;
    logic        ap_idle, ap_done, ap_ready, core_valid, core_stype, hit;
    logic [1:0]  core_slot;
    logic [31:0] nfa_beats, query_beats;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] m_tag [N];
    bit [N-1:0]  m_valid = '0;
    int          m_victim = 0;
    logic [31:0] pool [7] = '{32'hA5A5_0001, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};

    ederah_nfa_slot_ctrl dut (
        .clk_i(clk), .rst_i(rst), .ap_start_i(ap_start), .ap_idle_o(ap_idle),
        .ap_done_o(ap_done), .ap_ready_o(ap_ready), .nfa_hash_i(nfa_hash), .flush_i(flush),
        .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_i(in_ready),
        .core_valid_o(core_valid), .core_stype_o(core_stype), .core_slot_o(core_slot),
        .res_valid_i(res_valid), .res_ready_i(res_ready), .res_last_i(res_last),
        .hit_o(hit), .nfa_beats_o(nfa_beats), .query_beats_o(query_beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit stype, input int n);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 200) begin
            in_valid  = $urandom_range(3) != 0;
            in_ready  = $urandom_range(3) != 0;
            in_last   = sent == n - 1;
            res_valid = $urandom_range(1);
            res_ready = $urandom_range(1);
            res_last  = 0;
            if (stype)
                ap_start = $urandom_range(1);
            #1;
            if (in_valid) begin
                check("stype", core_stype, stype);
                check("core_valid", core_valid, 1);
            end
            check("no_early_done", ap_done, 0);
            if (in_valid && in_ready)
                sent++;
            guard++;
            step();
        end
        check("send_timeout", guard < 200, 1);
        in_valid = 0; in_last = 0; res_valid = 0; res_ready = 0; ap_start = 0;
    endtask

    task automatic run(input logic [31:0] h, input bit fl, input bit early, input int nn_in, input int nq);
        bit eh = 0;
        int es = 0;
        int nn;
        int k;
        if (fl)
            m_valid = '0;
        for (int i = 0; i < N; i++)
            if (!eh && m_valid[i] && m_tag[i] == h) begin
                eh = 1;
                es = i;
            end
        if (!eh) begin
            es = m_victim;
            m_valid[es] = 0;
        end
        nn = eh ? 0 : nn_in;
        check("idle_before", ap_idle, 1);
        ap_start = 1; nfa_hash = h; flush = fl;
        step();
        ap_start = 0; flush = 0;
        check("lookup_busy", ap_idle, 0);
        step();
        check("hit", hit, eh);
        check("slot", core_slot, es);
        if (early) begin
            res_valid = 1; res_ready = 1; res_last = 1;
            step();
            res_valid = 0; res_ready = 0; res_last = 0;
        end
        if (!eh) begin
            send(0, nn);
            m_tag[es] = h;
            m_valid[es] = 1;
            m_victim = (m_victim + 1) % N;
        end
        send(1, nq);
        in_valid = 1; in_ready = 1; in_last = 1;
        #1;
        check("drain_gated", core_valid, 0);
        if (!early) begin
            k = $urandom_range(3);
            repeat (k) begin
                step();
                check("drain_wait", ap_done, 0);
            end
            res_valid = 1; res_ready = 1; res_last = 1;
        end
        check("drain", ap_done, 0);
        step();
        res_valid = 0; res_ready = 0; res_last = 0;
        check("done", ap_done, 1);
        check("ready", ap_ready, 1);
        step();
        in_valid = 0; in_last = 0; in_ready = 0;
        check("done_pulse", ap_done, 0);
        check("idle_after", ap_idle, 1);
        check("nfa_beats", nfa_beats, nn);
        check("query_beats", query_beats, nq);
        check("hit_hold", hit, eh);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        step();
        step();
        check("rst_idle", ap_idle, 1);
        check("rst_done", ap_done, 0);
        check("rst_hit", hit, 0);
        check("rst_slot", core_slot, 0);
        check("rst_nfa", nfa_beats, 0);
        check("rst_query", query_beats, 0);
        rst = 0;
        step();
        run(32'hA5A5_0001, 0, 0, 3, 2);
        check("first_nfa3", nfa_beats, 3);
        run(32'hA5A5_0001, 0, 1, 3, 2);
        check("repeat_hit", hit, 1);
        run(32'hA5A5_0001, 1, 0, 2, 2);
        check("flush_miss", hit, 0);
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(7) == 0) begin
                flush = 1;
                step();
                flush = 0;
                m_valid = '0;
            end
            run(pool[$urandom_range(6)], $urandom_range(7) == 0, $urandom_range(1),
                $urandom_range(1, 4), $urandom_range(1, 4));
        end
        ap_start = 1; nfa_hash = 32'hDEAD_BEEF;
        step();
        ap_start = 0;
        step();
        in_valid = 1; in_ready = 1; in_last = 0;
        step();
        step();
        check("abort_nfa_cnt", nfa_beats, 2);
        rst = 1; in_valid = 0;
        step();
        rst = 0;
        check("abort_done", ap_done, 0);
        check("abort_idle", ap_idle, 1);
        check("abort_nfa", nfa_beats, 0);
        check("abort_slot", core_slot, 0);
        m_valid = '0;
        m_victim = 0;
        step();
        run(32'hDEAD_BEEF, 0, 0, 2, 1);
        check("abort_rerun_miss", hit, 0);
        for (int i = 0; i < 5; i++)
            run(32'h100 + i, 0, i % 2, 1, 1);
        run(32'h100, 0, 0, 1, 1);
        check("evicted_miss", hit, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
